// File: rtl/dco_pkg.sv
// Shared definitions for the DCO frequency-locked-loop controller.
// Holds the FSM state encoding, datapath widths, default parameter values
// and a saturating-increment helper for the edge counter.
package dco_pkg;

  localparam int CODE_W = 8;   // DCO control code width
  localparam int CNT_W  = 16;  // edge-count / target width

  localparam int DEF_WIN_CYCLES    = 256;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_DEADBAND      = 2;
  localparam int DEF_LOCK_N        = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    SAR_DECIDE,
    TRACK_DECIDE
  } fll_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/dco_edge_counter.sv
// Windowed DCO edge counter.
// dco_in is brought into the clk domain by a 2-FF synchronizer; a rising
// edge is a synchronized 0->1. A one-cycle start pulse opens a window of
// exactly WIN_CYCLES clk cycles (the start cycle included), during which
// detected edges are counted with saturation at all-ones.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   dco_in    - raw DCO output (asynchronous)
//   start     - opens a window; count is cleared in that cycle
//   abort     - drops the window in progress, no done is produced
//   done      - high in the last cycle of a window
//   count     - window total, valid while done is high
module dco_edge_counter
  import dco_pkg::*;
#(
  parameter int WIN_CYCLES = DEF_WIN_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dco_in,
  input  logic             start,
  input  logic             abort,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_CYCLES - 1);

  logic             sync1, sync2, sync_d;
  logic             active, running, last, rise;
  logic [CNT_W-1:0] cnt, cyc, base;

  assign rise    = sync2 & ~sync_d;
  assign running = (start | active) & ~abort;
  // The start cycle counts from zero, which is how the window clears.
  assign base    = start ? '0 : cnt;
  // count is the next value of the accumulator, so in the last window
  // cycle it already includes that cycle's edge and can be captured
  // together with done.
  assign count   = sat_inc(base, rise);
  assign last    = start ? (WIN_CYCLES == 1) : (cyc == LAST);
  assign done    = running & last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      cnt    <= '0;
      cyc    <= '0;
      active <= 1'b0;
    end else begin
      sync1  <= dco_in;
      sync2  <= sync1;
      sync_d <= sync2;
      if (running) begin
        cnt    <= count;
        active <= ~last;
        cyc    <= start ? CNT_W'(1) : cyc + CNT_W'(1);
      end else if (abort) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dco_fll_ctrl.sv
// DCO frequency-locked-loop controller.
// After enable, an 8-step successive-approximation pass picks the DCO code
// whose edge count per window is just below target, then the loop tracks
// with +/-1 code steps outside a deadband and reports lock after LOCK_N
// consecutive in-band windows. Each code change is followed by
// SETTLE_CYCLES idle cycles and a WIN_CYCLES measurement window.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - loop enable; low forces IDLE, code is held
//   dco_in     - DCO output (asynchronous to clk)
//   target     - desired rising-edge count per window
//   dco_code   - DCO control code (higher = faster)
//   meas_count - last completed window's edge count
//   meas_valid - one-cycle pulse when meas_count loads
//   locked     - loop in lock
module dco_fll_ctrl
  import dco_pkg::*;
#(
  parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,  // must be >= 1
  parameter int DEADBAND      = DEF_DEADBAND,
  parameter int LOCK_N        = DEF_LOCK_N          // must be 1..255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dco_in,
  input  logic [CNT_W-1:0]  target,
  output logic [CODE_W-1:0] dco_code,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_valid,
  output logic              locked
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W:0]   DB17        = (CNT_W+1)'(DEADBAND);
  localparam logic [CNT_W:0]   MAX17       = {1'b0, {CNT_W{1'b1}}};
  localparam logic [7:0]       LOCK_N8     = 8'(LOCK_N);

  fll_state_t        state;
  logic [2:0]        bit_idx;
  logic              sar_phase;
  logic [7:0]        lock_cnt;
  logic [CNT_W-1:0]  settle_cnt;
  logic              start;
  logic              win_done;
  logic [CNT_W-1:0]  win_count;
  logic              below, above, below_q, above_q;
  logic [CNT_W:0]    tgt17, cnt17, lo17, hi17;
  logic [CODE_W-1:0] sar_code;

  dco_edge_counter #(
    .WIN_CYCLES (WIN_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .dco_in (dco_in),
    .start  (start),
    .abort  (~en),
    .done   (win_done),
    .count  (win_count)
  );

  // Deadband test on the count that is about to load. 17 bits so the
  // band edges clamp at 0 and 16'hFFFF instead of wrapping.
  always_comb begin
    tgt17 = {1'b0, target};
    cnt17 = {1'b0, win_count};
    lo17  = (tgt17 >= DB17) ? tgt17 - DB17 : '0;
    hi17  = tgt17 + DB17;
    if (hi17 > MAX17) hi17 = MAX17;
    below = cnt17 < lo17;
    above = cnt17 > hi17;
  end

  // SAR trial: drop the current bit if the DCO ran at or above target,
  // then try the next lower bit.
  always_comb begin
    sar_code = dco_code;
    if (meas_count >= target) sar_code[bit_idx] = 1'b0;
    if (bit_idx != 3'd0) sar_code[bit_idx - 3'd1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dco_code   <= 8'h80;
      bit_idx    <= 3'd7;
      sar_phase  <= 1'b1;
      locked     <= 1'b0;
      lock_cnt   <= '0;
      settle_cnt <= '0;
      start      <= 1'b0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      below_q    <= 1'b0;
      above_q    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      start      <= 1'b0;
      if (!en) begin
        // Code is deliberately held; the edge counter aborts on ~en.
        state      <= IDLE;
        locked     <= 1'b0;
        lock_cnt   <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            dco_code   <= 8'h80;
            bit_idx    <= 3'd7;
            sar_phase  <= 1'b1;
            locked     <= 1'b0;
            lock_cnt   <= '0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              start      <= 1'b1;
              state      <= MEASURE;
            end else begin
              settle_cnt <= settle_cnt + CNT_W'(1);
            end
          end
          MEASURE: begin
            if (win_done) begin
              meas_count <= win_count;
              meas_valid <= 1'b1;
              below_q    <= below;
              above_q    <= above;
              if (sar_phase) begin
                state <= SAR_DECIDE;
              end else begin
                // Lock bookkeeping is done here so that locked is already
                // visible during the TRACK_DECIDE cycle it belongs to.
                state <= TRACK_DECIDE;
                if (below || above) begin
                  lock_cnt <= '0;
                  locked   <= 1'b0;
                end else begin
                  if (lock_cnt < LOCK_N8) lock_cnt <= lock_cnt + 8'd1;
                  if (lock_cnt + 8'd1 >= LOCK_N8) locked <= 1'b1;
                end
              end
            end
          end
          SAR_DECIDE: begin
            dco_code <= sar_code;
            if (bit_idx == 3'd0) sar_phase <= 1'b0;
            else                 bit_idx   <= bit_idx - 3'd1;
            state <= SETTLE;
          end
          TRACK_DECIDE: begin
            if (below_q) begin
              if (dco_code != 8'hFF) dco_code <= dco_code + 8'd1;
            end else if (above_q) begin
              if (dco_code != 8'h00) dco_code <= dco_code - 8'd1;
            end
            state <= SETTLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Directed bench for dco_fll_ctrl.
// The behavioural DCO is a phase accumulator stepped every 2 time units
// (offset by 1 so it never moves on a clk edge) with period 12800/(code+1).
// That keeps the DCO below f_clk/2 over the whole code range, and with a
// 640-cycle window (12800 time units) the count at code c is exactly c+1,
// so every expected value below is derived by hand from that relation.
module tb_dco_fll_ctrl;
  import dco_pkg::*;

  localparam int WIN    = 640;
  localparam int SET    = 16;
  localparam int DB     = 2;
  localparam int LN     = 4;
  localparam int PERIOD = SET + WIN + 1;

  // SAR walk for target 91 (count = code+1): meas per window, code after
  localparam int         SAR_MEAS [8] = '{129, 65, 97, 81, 89, 93, 91, 90};
  localparam logic [7:0] SAR_CODE [8] = '{8'h40, 8'h60, 8'h50, 8'h58,
                                          8'h5C, 8'h5A, 8'h59, 8'h59};

  logic        clk, rst, en, dco_in;
  logic [15:0] target;
  logic [7:0]  dco_code;
  logic [15:0] meas_count;
  logic        meas_valid, locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int acc     = 0;

  dco_fll_ctrl #(
    .WIN_CYCLES    (WIN),
    .SETTLE_CYCLES (SET),
    .DEADBAND      (DB),
    .LOCK_N        (LN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dco_in     (dco_in),
    .target     (target),
    .dco_code   (dco_code),
    .meas_count (meas_count),
    .meas_valid (meas_valid),
    .locked     (locked)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (meas_valid === 1'b1) n_pulse <= n_pulse + 1;

  initial begin
    dco_in = 1'b0;
    #1;
    forever begin
      #2;
      if (!$isunknown(dco_code)) begin
        acc = acc + 2 * (int'(dco_code) + 1);
        if (acc >= 12800) acc = acc - 12800;
      end
      dco_in = (acc >= 6400);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_decide(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         ok;
    int         t_prev, p0, em;
    logic [7:0] ec;

    // reset with en already high
    rst = 1'b1; en = 1'b1; target = 16'd91;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_code",   32'(dco_code), 32'h80);
    chk("rst_meas",   32'(meas_count), 32'h0);
    chk("rst_valid",  32'(meas_valid), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_state",  32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    // SAR pass
    p0 = n_pulse; t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      wait_decide(2 * PERIOD, ok);
      chk("sar_timeout", 32'(ok), 32'h1);
      if (!ok) break;
      chk("sar_meas", 32'(meas_count), SAR_MEAS[k]);
      if (k == 0) chk("sar_hold80", 32'(dco_code), 32'h80);
      else        chk("sar_gap", cyc - t_prev, PERIOD);
      t_prev = cyc;
      @(negedge clk);
      chk("sar_code", 32'(dco_code), 32'(SAR_CODE[k]));
    end
    chk("sar_pulses", n_pulse - p0, 8);
    chk("sar_near5A", 32'(dco_code >= 8'h59 && dco_code <= 8'h5B), 32'h1);

    // lock after 4 in-band windows
    for (int k = 0; k < 4; k++) begin
      wait_decide(2 * PERIOD, ok);
      chk("lock_timeout", 32'(ok), 32'h1);
      if (!ok) break;
      chk("lock_meas", 32'(meas_count), 90);
      chk("lock_flag", 32'(locked), 32'(k == 3));
      @(negedge clk);
      chk("lock_code", 32'(dco_code), 32'h59);
    end

    // target step +50: unlock, then +1 per window until in band
    target = 16'd141;
    ec = 8'h59;
    for (int k = 0; k < 60; k++) begin
      wait_decide(2 * PERIOD, ok);
      chk("step_timeout", 32'(ok), 32'h1);
      if (!ok) break;
      em = int'(ec) + 1;
      chk("step_meas", 32'(meas_count), em);
      if (k == 0) chk("step_unlock", 32'(locked), 32'h0);
      if (em < 139) ec = ec + 8'd1;
      @(negedge clk);
      chk("step_code", 32'(dco_code), 32'(ec));
      if (em >= 139) break;
    end
    chk("step_final", 32'(dco_code), 32'h8A);

    // disable between windows: code held, IDLE; then saturate high
    en = 1'b0;
    @(negedge clk);
    chk("dis_state", 32'(dut.state), 32'(IDLE));
    chk("dis_code",  32'(dco_code), 32'h8A);
    en = 1'b1; target = 16'hFFFF;
    for (int k = 0; k < 11; k++) begin
      wait_decide(2 * PERIOD, ok);
      chk("sathi_timeout", 32'(ok), 32'h1);
      if (!ok) break;
      @(negedge clk);
      if (k >= 7) chk("sat_hi", 32'(dco_code), 32'hFF);
    end

    // saturate low, and lock with the lower band edge clamped at 0
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; target = 16'd0;
    for (int k = 0; k < 12; k++) begin
      wait_decide(2 * PERIOD, ok);
      chk("satlo_timeout", 32'(ok), 32'h1);
      if (!ok) break;
      if (k >= 8) chk("sat_lo_lock", 32'(locked), 32'(k == 11));
      @(negedge clk);
      if (k >= 7) chk("sat_lo", 32'(dco_code), 32'h00);
    end

    // disable at half-window
    repeat (SET + WIN / 2) @(negedge clk);
    p0 = n_pulse;
    en = 1'b0;
    @(negedge clk);
    chk("mid_dis_state",  32'(dut.state), 32'(IDLE));
    chk("mid_dis_locked", 32'(locked), 32'h0);
    chk("mid_dis_code",   32'(dco_code), 32'h00);
    chk("mid_dis_valid",  32'(meas_valid), 32'h0);
    repeat (WIN) @(negedge clk);
    chk("mid_dis_pulses", n_pulse - p0, 0);

    // reset at half-window
    en = 1'b1; target = 16'd91;
    wait_decide(2 * PERIOD, ok);
    chk("rst2_timeout", 32'(ok), 32'h1);
    chk("rst2_meas0", 32'(meas_count), 129);
    @(negedge clk);
    chk("rst2_code0", 32'(dco_code), 32'h40);
    repeat (SET + WIN / 2) @(negedge clk);
    p0 = n_pulse;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_code",   32'(dco_code), 32'h80);
    chk("mid_rst_meas",   32'(meas_count), 32'h0);
    chk("mid_rst_valid",  32'(meas_valid), 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_state",  32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    repeat (WIN / 2 + 8) @(negedge clk);
    chk("mid_rst_pulses", n_pulse - p0, 0);
    wait_decide(2 * PERIOD, ok);
    chk("rst3_timeout", 32'(ok), 32'h1);
    chk("rst3_meas", 32'(meas_count), 129);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
